uart_ctrl_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/uart_ctrl_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_ctrl_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver / controller-command decoder.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_JUMP   = 2;
  localparam int BTN_SQUAT  = 3;
  localparam int BTN_ATTACK = 4;
  localparam int BTN_DEFEND = 5;
  localparam int BTN_SELECT = 6;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on o_data while !o_empty.
// Pointers carry one wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_q == rd_q);
  assign o_full  = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= i_data;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign o_data = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_ctrl_rx.sv
// Oversampling UART receiver with optional parity, byte FIFO, line-error pulses
// and auto-releasing button outputs decoded from the received bytes.
module uart_ctrl_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 938,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLD_CYCLES  = 2_700_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_rd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_right,
  output logic                 o_left,
  output logic                 o_jump,
  output logic                 o_squat,
  output logic                 o_attack,
  output logic                 o_defend,
  output logic                 o_select,
  output uart_state_e          o_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic                 rx_meta_q;
  logic                 rxs;
  uart_state_e          state_q;
  uart_state_e          state_d;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 good_stb_q;
  logic                 ferr_q;
  logic                 perr_q;
  logic [6:0]           btn_q;
  logic [HW-1:0]        hold_q;
  logic                 hold_act_q;

  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 take_data;
  logic                 take_par;
  logic                 stop_good;
  logic                 stop_ferr;
  logic                 stop_perr;
  logic                 bit_tick;
  logic                 par_ok;
  logic [7:0]           byte_w;
  logic                 fifo_full;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rxs       <= rx_meta_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign bit_tick = (cnt_q == CNT_LAST);

  always_comb begin
    par_ok = 1'b1;
    case (PARITY)
      PAR_ODD:  par_ok = ^{shift_q, par_q};
      PAR_EVEN: par_ok = ~^{shift_q, par_q};
      default:  par_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    take_data = 1'b0;
    take_par  = 1'b0;
    stop_good = 1'b0;
    stop_ferr = 1'b0;
    stop_perr = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        // Mid-bit recheck rejects short glitches on the idle line.
        if (cnt_q == CNT_HALF) begin
          cnt_clr = 1'b1;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_clr   = 1'b1;
          take_data = 1'b1;
          if (bit_q == BIT_LAST) state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_clr  = 1'b1;
          take_par = 1'b1;
          state_d  = S_STOP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_clr = 1'b1;
          if (!rxs) begin
            stop_ferr = 1'b1;
            state_d   = S_WAIT_HIGH;
          end else if (!par_ok) begin
            stop_perr = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stop_good = 1'b1;
            state_d   = S_IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      good_stb_q <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (state_q != S_DATA) bit_q <= '0;
      else if (take_data)    bit_q <= bit_q + 1'b1;
      if (take_data) shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
      if (take_par)  par_q   <= rxs;
      good_stb_q <= stop_good;
      ferr_q     <= stop_ferr;
      perr_q     <= stop_perr;
    end
  end

  // Zero-extend narrow frames so unused button bits read as 0.
  always_comb begin
    byte_w                = '0;
    byte_w[DATA_BITS-1:0] = shift_q;
  end

  // Every good byte reloads the buttons, even one the full FIFO drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btn_q      <= '0;
      hold_q     <= '0;
      hold_act_q <= 1'b0;
    end else if (good_stb_q) begin
      btn_q      <= byte_w[6:0];
      hold_q     <= '0;
      hold_act_q <= (byte_w != 8'h00);
    end else if (hold_act_q) begin
      if (hold_q == HOLD_LAST) begin
        btn_q      <= '0;
        hold_act_q <= 1'b0;
      end else begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (good_stb_q),
    .i_pop   (i_rd),
    .i_data  (shift_q),
    .o_data  (o_data),
    .o_full  (fifo_full),
    .o_empty (o_empty)
  );

  assign o_full       = fifo_full;
  assign o_overrun    = good_stb_q & fifo_full & ~i_rd;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_state      = state_q;

  assign o_right  = btn_q[BTN_RIGHT];
  assign o_left   = btn_q[BTN_LEFT];
  assign o_jump   = btn_q[BTN_JUMP];
  assign o_squat  = btn_q[BTN_SQUAT];
  assign o_attack = btn_q[BTN_ATTACK];
  assign o_defend = btn_q[BTN_DEFEND];
  assign o_select = btn_q[BTN_SELECT];

endmodule

// File: tb/tb_uart_ctrl_rx.sv
// Directed bench for uart_ctrl_rx: an 8N1 instance and an even-parity instance.
module tb_uart_ctrl_rx;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int HOLD = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       rx0 = 1'b1, rd0 = 1'b0;
  logic       rx2 = 1'b1, rd2 = 1'b0;
  logic [7:0] data0, data2;
  logic       empty0, full0, ferr0, perr0, ovr0;
  logic       empty2, full2, ferr2, perr2, ovr2;
  logic [6:0] btn0, btn2;
  uart_state_e st0, st2;

  uart_ctrl_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE),
                 .FIFO_DEPTH(4), .HOLD_CYCLES(HOLD)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx0), .i_rd(rd0),
    .o_data(data0), .o_empty(empty0), .o_full(full0),
    .o_frame_err(ferr0), .o_parity_err(perr0), .o_overrun(ovr0),
    .o_right(btn0[0]), .o_left(btn0[1]), .o_jump(btn0[2]), .o_squat(btn0[3]),
    .o_attack(btn0[4]), .o_defend(btn0[5]), .o_select(btn0[6]),
    .o_state(st0)
  );

  uart_ctrl_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN),
                 .FIFO_DEPTH(4), .HOLD_CYCLES(HOLD)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_rx(rx2), .i_rd(rd2),
    .o_data(data2), .o_empty(empty2), .o_full(full2),
    .o_frame_err(ferr2), .o_parity_err(perr2), .o_overrun(ovr2),
    .o_right(btn2[0]), .o_left(btn2[1]), .o_jump(btn2[2]), .o_squat(btn2[3]),
    .o_attack(btn2[4]), .o_defend(btn2[5]), .o_select(btn2[6]),
    .o_state(st2)
  );

  // ---------------- pulse / hold monitors ----------------
  int fe0_cnt = 0, pe0_cnt = 0, ov0_cnt = 0;
  int fe2_cnt = 0, pe2_cnt = 0, ov2_cnt = 0;
  int right_run = 0, right_len = 0;

  always @(negedge clk) begin
    if (ferr0) fe0_cnt++;
    if (perr0) pe0_cnt++;
    if (ovr0)  ov0_cnt++;
    if (ferr2) fe2_cnt++;
    if (perr2) pe2_cnt++;
    if (ovr2)  ov2_cnt++;
    if (btn0[BTN_RIGHT]) right_run++;
    else if (right_run != 0) begin
      right_len = right_run;
      right_run = 0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx0 = bits[i];
      else            rx2 = bits[i];
      wait_clks(CPB);
    end
    if (which == 0) rx0 = 1'b1;
    else            rx2 = 1'b1;
  endtask

  task automatic send_8n1(input logic [7:0] b);
    send_bits(0, {6'b0, 1'b1, b, 1'b0}, 10);
  endtask

  task automatic send_par(input logic [7:0] b, input logic p);
    send_bits(2, {5'b0, 1'b1, p, b, 1'b0}, 11);
  endtask

  task automatic pop0;
    rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
  endtask

  task automatic pop2;
    rd2 = 1'b1;
    @(negedge clk);
    rd2 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [6:0] btn;
  } vec_t;

  vec_t vecs[6];
  int   fe_ref, pe_ref, ov_ref;

  initial begin
    vecs[0] = '{tx: 8'h05, btn: 7'h05};
    vecs[1] = '{tx: 8'h7F, btn: 7'h7F};
    vecs[2] = '{tx: 8'h00, btn: 7'h00};
    vecs[3] = '{tx: 8'hA5, btn: 7'h25};
    vecs[4] = '{tx: 8'h80, btn: 7'h00};
    vecs[5] = '{tx: 8'h40, btn: 7'h40};

    // reset state
    wait_clks(4);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_data", 32'(data0), 32'h0);
    chk("rst_btn", 32'(btn0), 32'h0);
    chk("rst_pulses", {29'd0, ferr0, perr0, ovr0}, 32'h0);
    chk("rst_state", 32'(st0), 32'(S_IDLE));
    rst = 1'b0;
    wait_clks(4);

    // 0x05 then exact hold release
    send_8n1(8'h05);
    wait_clks(2);
    chk("hold_btn_on", 32'(btn0), 32'h05);
    chk("hold_data", 32'(data0), 32'h05);
    chk("hold_empty", 32'(empty0), 32'd0);
    wait_clks(HOLD + 50);
    chk("hold_btn_off", 32'(btn0), 32'h0);
    chk("hold_len", 32'(right_len), 32'(HOLD));
    pop0;
    chk("hold_pop_empty", 32'(empty0), 32'd1);

    // table of 8N1 bytes: FIFO head and button decode
    ov_ref = ov0_cnt;
    for (int v = 0; v < 6; v++) begin
      send_8n1(vecs[v].tx);
      wait_clks(2);
      chk($sformatf("vec%0d_empty", v), 32'(empty0), 32'd0);
      chk($sformatf("vec%0d_data", v), 32'(data0), 32'(vecs[v].tx));
      chk($sformatf("vec%0d_btn", v), 32'(btn0), 32'(vecs[v].btn));
      pop0;
      chk($sformatf("vec%0d_popped", v), 32'(empty0), 32'd1);
    end
    chk("vec_no_overrun", 32'(ov0_cnt - ov_ref), 32'd0);

    // even parity: good 0x03 (p=0), then bad 0x03 (p=1)
    send_par(8'h03, 1'b0);
    wait_clks(2);
    chk("par_good_data", 32'(data2), 32'h03);
    chk("par_good_btn", 32'(btn2), 32'h03);
    pop2;
    pe_ref = pe2_cnt;
    send_par(8'h03, 1'b1);
    wait_clks(2);
    chk("par_err_pulses", 32'(pe2_cnt - pe_ref), 32'd1);
    chk("par_err_empty", 32'(empty2), 32'd1);
    chk("par_err_btn", 32'(btn2), 32'h03);
    chk("par_no_ferr", 32'(fe2_cnt), 32'd0);

    // break: line low for 20 bit-times
    fe_ref = fe0_cnt;
    pe_ref = pe0_cnt;
    rx0 = 1'b0;
    wait_clks(20 * CPB);
    chk("brk_state", 32'(st0), 32'(S_WAIT_HIGH));
    chk("brk_ferr", 32'(fe0_cnt - fe_ref), 32'd1);
    chk("brk_empty", 32'(empty0), 32'd1);
    rx0 = 1'b1;
    wait_clks(CPB);
    chk("brk_idle", 32'(st0), 32'(S_IDLE));
    send_8n1(8'h40);
    wait_clks(2);
    chk("brk_select", 32'(btn0[BTN_SELECT]), 32'd1);
    chk("brk_data", 32'(data0), 32'h40);
    chk("brk_ferr_total", 32'(fe0_cnt - fe_ref), 32'd1);
    chk("brk_no_perr", 32'(pe0_cnt - pe_ref), 32'd0);
    pop0;

    // overflow: five bytes, no reads
    ov_ref = ov0_cnt;
    for (int b = 1; b <= 4; b++) send_8n1(8'(b));
    wait_clks(2);
    chk("ovf_full4", 32'(full0), 32'd1);
    chk("ovf_none_yet", 32'(ov0_cnt - ov_ref), 32'd0);
    send_8n1(8'h05);
    wait_clks(2);
    chk("ovf_pulse", 32'(ov0_cnt - ov_ref), 32'd1);
    chk("ovf_full5", 32'(full0), 32'd1);
    chk("ovf_btn", 32'(btn0), 32'h05);
    for (int b = 1; b <= 4; b++) begin
      chk($sformatf("ovf_pop%0d", b), 32'(data0), 32'(b));
      pop0;
    end
    chk("ovf_drained", 32'(empty0), 32'd1);
    chk("ovf_not_full", 32'(full0), 32'd0);

    // 4-clock glitch
    fe_ref = fe0_cnt;
    pe_ref = pe0_cnt;
    ov_ref = ov0_cnt;
    rx0 = 1'b0;
    wait_clks(4);
    rx0 = 1'b1;
    wait_clks(3 * CPB);
    chk("glitch_state", 32'(st0), 32'(S_IDLE));
    chk("glitch_empty", 32'(empty0), 32'd1);
    chk("glitch_flags", 32'((fe0_cnt - fe_ref) + (pe0_cnt - pe_ref) + (ov0_cnt - ov_ref)), 32'd0);

    // reset during DATA, then a clean 0x10
    send_8n1(8'h7F);
    wait_clks(2);
    chk("mid_pre_btn", 32'(btn0), 32'h7F);
    rx0 = 1'b0;
    wait_clks(3 * CPB);
    chk("mid_in_data", 32'(st0), 32'(S_DATA));
    rst = 1'b1;
    rx0 = 1'b1;
    #1;
    chk("mid_rst_state", 32'(st0), 32'(S_IDLE));
    chk("mid_rst_btn", 32'(btn0), 32'h0);
    chk("mid_rst_empty", 32'(empty0), 32'd1);
    chk("mid_rst_data", 32'(data0), 32'h0);
    wait_clks(2);
    rst = 1'b0;
    fe_ref = fe0_cnt;
    wait_clks(12 * CPB);
    chk("mid_no_push", 32'(empty0), 32'd1);
    chk("mid_no_ferr", 32'(fe0_cnt - fe_ref), 32'd0);
    send_8n1(8'h10);
    wait_clks(2);
    chk("mid_attack", 32'(btn0), 32'h10);
    chk("mid_data", 32'(data0), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
